cci_mpf_shim_buffer_tx: RTL and testbench
=========================================

Name: cci_mpf_shim_buffer_tx

Overview:
- Parametrised per-channel request buffer between AFU-side and FIU-side CCI MPF request channels.
- Supports N_CHAN request channels (c0/c1 today, more for multi-port FIUs).
- Absorbs requests the AFU issues after almost-full.
- Drives its own almost-full toward the AFU from a programmable free-slot threshold.
- Forwards one request per channel per cycle whenever the FIU is not almost-full.

Parameters:
- N_CHAN, 2: number of independent request channels.
- REQ_WIDTH, 600: packed request payload width (header plus data) per channel.
- DEPTH, 16: FIFO entries per channel; power of two, at least 4.
- ALMFULL_SLOTS, 4: AFU almost-full asserts when free entries are at or below this value; must be less than DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- afu_tx_valid  in  N_CHAN  request valid per channel, AFU side.
- afu_tx_req  in  N_CHAN*REQ_WIDTH  request payload; channel c occupies slice c.
- afu_tx_almfull  out  N_CHAN  almost-full toward AFU.
- fiu_tx_valid  out  N_CHAN  request valid per channel, FIU side.
- fiu_tx_req  out  N_CHAN*REQ_WIDTH  forwarded payload.
- fiu_tx_almfull  in  N_CHAN  almost-full from FIU.
- overflow  out  N_CHAN  sticky: a request arrived to a full FIFO.

Interface decision: one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset values while reset is high, and the cycle it is sampled:
  - count = 0, rd/wr pointers = 0
  - fiu_tx_valid = 0, fiu_tx_req = 0, overflow = 0
  - afu_tx_almfull = all ones; it deasserts the first cycle after reset drops
- Reset mid-operation discards all buffered entries; no partial output.
- Channels are fully independent; no arbitration between channels.
- Enqueue on channel c when afu_tx_valid[c] = 1 at a rising edge.
- Accept condition: count < DEPTH, or a dequeue on the same channel in the same cycle (full plus simultaneous deq accepts).
- Full with no deq: request dropped, overflow[c] set, stays set until reset.
- Dequeue condition: count > 0 and fiu_tx_almfull[c] = 0, sampled the same cycle. The head is registered into fiu_tx_req; fiu_tx_valid[c] = 1 next cycle, otherwise 0.
- Minimum latency: request at edge t -> fiu_tx_valid at edge t+2. An entry written at t is countable at t+1 and dequeued then.
- count_next = count + enq - deq; width $clog2(DEPTH+1).
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- afu_tx_almfull[c] is registered: next value = (DEPTH - count_next) <= ALMFULL_SLOTS.
- fiu_tx_almfull rising stops dequeue the same cycle; a request already registered still presents one cycle. This is legal under CCI almost-full slack.
- Empty with fiu_tx_almfull low: fiu_tx_valid = 0; no bubbles are inserted otherwise, so sustained throughput is 1/cycle/channel.

Optional Feature:
- Macro CCI_MPF_SHIM_BUFFER_TX_STATS_EN.
- When defined:
  - Adds output hwm, N_CHAN*$clog2(DEPTH+1): per-channel high-water mark of count, updated every cycle as max(hwm, count_next), cleared by reset.
  - Adds output stall_cycles, N_CHAN*32: increments when count > 0 and fiu_tx_almfull[c] = 1; saturates at all-ones.
- When undefined: ports absent, no counter logic; all other behaviour identical.

Decomposition:
- Package cci_mpf_shim_buffer_pkg holds:
  - derived width functions: count width, pointer width
  - typedef t_buf_count
  - localparam-check helper asserting ALMFULL_SLOTS < DEPTH and DEPTH a power of two (elaboration-time $error)
- Sub-module cci_mpf_shim_buffer_fifo: single-channel FIFO with count, almost-full and overflow, instantiated N_CHAN times in a generate loop.
- Top level holds only payload slicing and the optional stats.

Test Plan:
1. Reset: reset high 3 cycles, then low -> afu_tx_almfull = 2'b11 through reset, 2'b00 next cycle; fiu_tx_valid = 0, overflow = 0.
2. Latency/order: DEPTH=16, fiu_tx_almfull=0, ch0 requests payloads 1..20 back-to-back -> fiu_tx_valid[0] rises 2 cycles after first; payloads 1..20 appear in order on consecutive cycles.
3. Almost-full threshold: fiu_tx_almfull[1]=1, push 12 requests on ch1 -> afu_tx_almfull[1] = 1 in the cycle after the 12th enqueue (free = 4); 11 pushes -> stays 0.
4. Overflow: hold fiu_tx_almfull[0]=1, push 17 -> the 17th is dropped and overflow[0]=1. Release -> exactly 16 requests emitted; overflow stays 1.
5. Full plus simultaneous deq: count=16, fiu_tx_almfull low and enqueue the same cycle -> accepted, count stays 16, no overflow.
6. Wrap and stats (macro defined): 40 requests through DEPTH=16 with alternating FIU almost-full -> data intact across pointer wrap; hwm equals the peak count; stall_cycles equals the number of almost-full cycles with a non-empty FIFO.

Source files
------------

// File: rtl/cci_mpf_shim_buffer_pkg.sv
// rtl/cci_mpf_shim_buffer_pkg.sv - shared widths, types and parameter checks for the tx request buffer
//
// Purpose: derived width helpers used by the FIFO and the top level, a default
//          count type, and a parameter sanity helper used at elaboration.
// Ports:   none (package).
package cci_mpf_shim_buffer_pkg;

  localparam int DEFAULT_DEPTH = 16;

  // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH + 1)-1:0] t_buf_count;

  // True when DEPTH is a power of two of at least 4 and the almost-full
  // threshold leaves at least one slot below it.
  function automatic bit params_ok(input int depth, input int almfull_slots);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (almfull_slots >= 0) && (almfull_slots < depth);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_buffer_fifo.sv
// rtl/cci_mpf_shim_buffer_fifo.sv - single-channel request FIFO with almost-full and sticky overflow
//
// Purpose: buffers one request channel between AFU and FIU. A request written
//          at edge t is visible in count at t+1 and can be dequeued then, so
//          fiu_valid rises at t+2 at the earliest.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   afu_valid/req   incoming request
//   afu_almfull     registered almost-full toward the AFU (free <= ALMFULL_SLOTS)
//   fiu_valid/req   registered outgoing request
//   fiu_almfull     almost-full from the FIU; blocks dequeue the same cycle
//   count_next      next occupancy        (CCI_MPF_SHIM_BUFFER_TX_STATS_EN only)
//   stalled         non-empty and blocked (CCI_MPF_SHIM_BUFFER_TX_STATS_EN only)
//   overflow        sticky: a request hit a full FIFO with no dequeue
module cci_mpf_shim_buffer_fifo
  import cci_mpf_shim_buffer_pkg::*;
#(
  parameter int REQ_WIDTH     = 600,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLOTS = 4,
  localparam int CW = count_width(DEPTH),
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 afu_valid,
  input  logic [REQ_WIDTH-1:0] afu_req,
  output logic                 afu_almfull,
  output logic                 fiu_valid,
  output logic [REQ_WIDTH-1:0] fiu_req,
  input  logic                 fiu_almfull,
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
  output logic [CW-1:0]        count_next,
  output logic                 stalled,
`endif
  output logic                 overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SLOTS_C = CW'(ALMFULL_SLOTS);

  if (!params_ok(DEPTH, ALMFULL_SLOTS)) begin : g_param_err
    $error("cci_mpf_shim_buffer_fifo: DEPTH must be a power of two >= 4 and ALMFULL_SLOTS < DEPTH");
  end

  logic [REQ_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 full;
  logic                 enq;
  logic                 deq;

  // A full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    full      = (count == DEPTH_C);
    deq       = (count != '0) && !fiu_almfull;
    enq       = afu_valid && (!full || deq);
    count_nxt = count + CW'(enq) - CW'(deq);
  end

`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
  assign count_next = count_nxt;
  assign stalled    = (count != '0) && fiu_almfull;
`endif

  // Payload storage carries no reset; reset empties the FIFO through count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= afu_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fiu_valid   <= 1'b0;
      fiu_req     <= '0;
      afu_almfull <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      count     <= count_nxt;
      fiu_valid <= deq;
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr  <= rd_ptr + PW'(1);
        fiu_req <= mem[rd_ptr];
      end
      afu_almfull <= (DEPTH_C - count_nxt) <= SLOTS_C;
      if (afu_valid && full && !deq) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cci_mpf_shim_buffer_tx.sv
// rtl/cci_mpf_shim_buffer_tx.sv - per-channel CCI MPF tx request buffer (top)
//
// Purpose: one independent FIFO per request channel; absorbs AFU requests
//          issued after almost-full and forwards whenever the FIU allows.
//          Optional statistics under macro CCI_MPF_SHIM_BUFFER_TX_STATS_EN.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   afu_tx_valid     [N_CHAN]            AFU request valid
//   afu_tx_req       [N_CHAN*REQ_WIDTH]  AFU payload, channel c in slice c
//   afu_tx_almfull   [N_CHAN]            almost-full toward AFU
//   fiu_tx_valid     [N_CHAN]            FIU request valid
//   fiu_tx_req       [N_CHAN*REQ_WIDTH]  FIU payload
//   fiu_tx_almfull   [N_CHAN]            almost-full from FIU
//   hwm              [N_CHAN*CW]         high-water mark of count (stats only)
//   stall_cycles     [N_CHAN*32]         saturating blocked-cycle count (stats only)
//   overflow         [N_CHAN]            sticky drop indication
module cci_mpf_shim_buffer_tx
  import cci_mpf_shim_buffer_pkg::*;
#(
  parameter int N_CHAN        = 2,
  parameter int REQ_WIDTH     = 600,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLOTS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CHAN-1:0]             afu_tx_valid,
  input  logic [N_CHAN*REQ_WIDTH-1:0]   afu_tx_req,
  output logic [N_CHAN-1:0]             afu_tx_almfull,
  output logic [N_CHAN-1:0]             fiu_tx_valid,
  output logic [N_CHAN*REQ_WIDTH-1:0]   fiu_tx_req,
  input  logic [N_CHAN-1:0]             fiu_tx_almfull,
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
  output logic [N_CHAN*count_width(DEPTH)-1:0] hwm,
  output logic [N_CHAN*32-1:0]          stall_cycles,
`endif
  output logic [N_CHAN-1:0]             overflow
);

  localparam int CW = count_width(DEPTH);

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
    logic [CW-1:0] count_next;
    logic          stalled;
    logic [CW-1:0] hwm_q;
    logic [31:0]   stall_q;
`endif

    cci_mpf_shim_buffer_fifo #(
      .REQ_WIDTH     (REQ_WIDTH),
      .DEPTH         (DEPTH),
      .ALMFULL_SLOTS (ALMFULL_SLOTS)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .afu_valid   (afu_tx_valid[c]),
      .afu_req     (afu_tx_req[c*REQ_WIDTH +: REQ_WIDTH]),
      .afu_almfull (afu_tx_almfull[c]),
      .fiu_valid   (fiu_tx_valid[c]),
      .fiu_req     (fiu_tx_req[c*REQ_WIDTH +: REQ_WIDTH]),
      .fiu_almfull (fiu_tx_almfull[c]),
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
      .count_next  (count_next),
      .stalled     (stalled),
`endif
      .overflow    (overflow[c])
    );

`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
    always_ff @(posedge clk) begin
      if (reset) begin
        hwm_q   <= '0;
        stall_q <= '0;
      end else begin
        if (count_next > hwm_q) begin
          hwm_q <= count_next;
        end
        if (stalled && (stall_q != '1)) begin
          stall_q <= stall_q + 32'd1;
        end
      end
    end

    assign hwm[c*CW +: CW]          = hwm_q;
    assign stall_cycles[c*32 +: 32] = stall_q;
`endif
  end

endmodule

// File: tb/tb_cci_mpf_shim_buffer_tx.sv
// tb/tb_cci_mpf_shim_buffer_tx.sv - self-checking bench for cci_mpf_shim_buffer_tx
module tb_cci_mpf_shim_buffer_tx;

  localparam int N_CHAN        = 2;
  localparam int REQ_WIDTH     = 32;
  localparam int DEPTH         = 16;
  localparam int ALMFULL_SLOTS = 4;
  localparam int CW            = $clog2(DEPTH + 1);

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N_CHAN-1:0]           afu_tx_valid;
  logic [N_CHAN*REQ_WIDTH-1:0] afu_tx_req;
  logic [N_CHAN-1:0]           afu_tx_almfull;
  logic [N_CHAN-1:0]           fiu_tx_valid;
  logic [N_CHAN*REQ_WIDTH-1:0] fiu_tx_req;
  logic [N_CHAN-1:0]           fiu_tx_almfull;
  logic [N_CHAN-1:0]           overflow;
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
  logic [N_CHAN*CW-1:0]        hwm;
  logic [N_CHAN*32-1:0]        stall_cycles;
`endif

  always #5 clk = ~clk;

  cci_mpf_shim_buffer_tx #(
    .N_CHAN        (N_CHAN),
    .REQ_WIDTH     (REQ_WIDTH),
    .DEPTH         (DEPTH),
    .ALMFULL_SLOTS (ALMFULL_SLOTS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .afu_tx_valid   (afu_tx_valid),
    .afu_tx_req     (afu_tx_req),
    .afu_tx_almfull (afu_tx_almfull),
    .fiu_tx_valid   (fiu_tx_valid),
    .fiu_tx_req     (fiu_tx_req),
    .fiu_tx_almfull (fiu_tx_almfull),
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
    .hwm            (hwm),
    .stall_cycles   (stall_cycles),
`endif
    .overflow       (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue per channel plus the expected outputs.
  logic [REQ_WIDTH-1:0] q [N_CHAN][$];
  bit                   m_valid [N_CHAN];
  logic [REQ_WIDTH-1:0] m_req   [N_CHAN];
  bit                   m_almf  [N_CHAN];
  bit                   m_ovf   [N_CHAN];
  int                   m_hwm   [N_CHAN];
  longint               m_stall [N_CHAN];
  int                   emitted [N_CHAN];

  task automatic cmp(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d @%0t: got %0h expected %0h", name, c, $time, act, exp);
    end
  endtask

  task automatic model_edge(input int c);
    if (reset) begin
      q[c].delete();
      m_valid[c] = 1'b0;
      m_almf[c]  = 1'b1;
      m_ovf[c]   = 1'b0;
      m_hwm[c]   = 0;
      m_stall[c] = 0;
    end else begin
      int n;
      bit deq;
      n   = q[c].size();
      deq = (n > 0) && !fiu_tx_almfull[c];
      m_valid[c] = deq;
      if (deq) m_req[c] = q[c].pop_front();
      if (afu_tx_valid[c]) begin
        if (n < DEPTH || deq) q[c].push_back(afu_tx_req[c*REQ_WIDTH +: REQ_WIDTH]);
        else m_ovf[c] = 1'b1;
      end
      m_almf[c] = (DEPTH - q[c].size()) <= ALMFULL_SLOTS;
      if (q[c].size() > m_hwm[c]) m_hwm[c] = q[c].size();
      if (n > 0 && fiu_tx_almfull[c] && m_stall[c] != 64'hffff_ffff) m_stall[c]++;
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < N_CHAN; c++) begin
      cmp("fiu_tx_valid", c, 64'(fiu_tx_valid[c]), 64'(m_valid[c]));
      if (m_valid[c]) cmp("fiu_tx_req", c, 64'(fiu_tx_req[c*REQ_WIDTH +: REQ_WIDTH]), 64'(m_req[c]));
      cmp("afu_tx_almfull", c, 64'(afu_tx_almfull[c]), 64'(m_almf[c]));
      cmp("overflow", c, 64'(overflow[c]), 64'(m_ovf[c]));
`ifdef CCI_MPF_SHIM_BUFFER_TX_STATS_EN
      cmp("hwm", c, 64'(hwm[c*CW +: CW]), 64'(m_hwm[c]));
      cmp("stall_cycles", c, 64'(stall_cycles[c*32 +: 32]), 64'(m_stall[c]));
`endif
      if (fiu_tx_valid[c] === 1'b1) emitted[c]++;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    for (int c = 0; c < N_CHAN; c++) model_edge(c);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int cycles);
    afu_tx_valid = '0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_reset(input int cycles);
    reset        = 1'b1;
    afu_tx_valid = '0;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    int first_idx;
    int last_idx;
    int n_obs;
    int order_ok;

    reset          = 1'b1;
    afu_tx_valid   = '0;
    afu_tx_req     = '0;
    fiu_tx_almfull = '0;
    for (int c = 0; c < N_CHAN; c++) emitted[c] = 0;

    // Reset: almost-full high throughout, low the cycle after release.
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("rst_almfull_lit", 0, 64'(afu_tx_almfull), 64'h3);
      cmp("rst_valid_lit", 0, 64'(fiu_tx_valid), 64'h0);
      cmp("rst_overflow_lit", 0, 64'(overflow), 64'h0);
    end
    reset = 1'b0;
    step();
    cmp("post_rst_almfull_lit", 0, 64'(afu_tx_almfull), 64'h0);

    // Latency and ordering: payloads 1..20 back-to-back on ch0.
    first_idx = -1;
    last_idx  = -1;
    n_obs     = 0;
    order_ok  = 1;
    for (int i = 0; i < 26; i++) begin
      afu_tx_valid[0] = (i < 20);
      afu_tx_req[0 +: REQ_WIDTH] = REQ_WIDTH'(i + 1);
      step();
      if (fiu_tx_valid[0] === 1'b1) begin
        if (first_idx < 0) first_idx = i;
        last_idx = i;
        n_obs++;
        if (fiu_tx_req[0 +: REQ_WIDTH] !== REQ_WIDTH'(n_obs)) order_ok = 0;
      end
    end
    cmp("first_valid_idx_lit", 0, 64'(first_idx), 64'd1);
    cmp("valid_span_lit", 0, 64'(last_idx - first_idx), 64'd19);
    cmp("emitted_cnt_lit", 0, 64'(n_obs), 64'd20);
    cmp("order_lit", 0, 64'(order_ok), 64'd1);

    // Almost-full threshold on ch1: 11 entries keep it low, the 12th raises it.
    fiu_tx_almfull[1] = 1'b1;
    afu_tx_valid[1]   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      afu_tx_req[REQ_WIDTH +: REQ_WIDTH] = REQ_WIDTH'($urandom);
      step();
      if (i == 10) cmp("almfull_11_lit", 1, 64'(afu_tx_almfull[1]), 64'd0);
      if (i == 11) cmp("almfull_12_lit", 1, 64'(afu_tx_almfull[1]), 64'd1);
    end
    fiu_tx_almfull[1] = 1'b0;
    idle(20);

    // Overflow: 17 pushes into a blocked ch0, then drain exactly 16.
    fiu_tx_almfull[0] = 1'b1;
    afu_tx_valid[0]   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      afu_tx_req[0 +: REQ_WIDTH] = REQ_WIDTH'(32'h100 + i);
      step();
      if (i == 15) cmp("ovf_at_16_lit", 0, 64'(overflow[0]), 64'd0);
    end
    cmp("ovf_at_17_lit", 0, 64'(overflow[0]), 64'd1);
    afu_tx_valid[0]   = 1'b0;
    fiu_tx_almfull[0] = 1'b0;
    emitted[0] = 0;
    idle(22);
    cmp("ovf_drain_cnt_lit", 0, 64'(emitted[0]), 64'd16);
    cmp("ovf_sticky_lit", 0, 64'(overflow[0]), 64'd1);

    // Full plus simultaneous dequeue: accepted, no overflow.
    do_reset(2);
    fiu_tx_almfull[0] = 1'b1;
    afu_tx_valid[0]   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      afu_tx_req[0 +: REQ_WIDTH] = REQ_WIDTH'(32'h200 + i);
      step();
    end
    fiu_tx_almfull[0] = 1'b0;
    emitted[0] = 0;
    for (int i = 0; i < 3; i++) begin
      afu_tx_req[0 +: REQ_WIDTH] = REQ_WIDTH'(32'h300 + i);
      step();
      cmp("full_deq_almfull_lit", 0, 64'(afu_tx_almfull[0]), 64'd1);
    end
    idle(22);
    cmp("full_deq_ovf_lit", 0, 64'(overflow[0]), 64'd0);
    cmp("full_deq_cnt_lit", 0, 64'(emitted[0]), 64'd19);

    // Randomized traffic with wrap, back-pressure and a mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      reset = (i >= 1000 && i < 1003);
      for (int c = 0; c < N_CHAN; c++) begin
        afu_tx_valid[c]   = ($urandom_range(99) < 65);
        fiu_tx_almfull[c] = ($urandom_range(99) < 35);
        afu_tx_req[c*REQ_WIDTH +: REQ_WIDTH] = REQ_WIDTH'($urandom);
      end
      step();
    end
    reset = 1'b0;
    fiu_tx_almfull = '0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
